// File: rtl/regfile_write_scheduler_pkg.sv
// Shared widths and constants for the register-file write scheduler.
package mips_rf_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Writeback requests, register-file write port and decode hazard lookup.
interface regfile_write_scheduler_if #(
  parameter int NREQ   = 2,
  parameter int DATA_W = mips_rf_pkg::DATA_W,
  parameter int ADDR_W = mips_rf_pkg::ADDR_W
);
  logic [NREQ-1:0]             wb_valid;
  logic [NREQ-1:0][ADDR_W-1:0] wb_addr;
  logic [NREQ-1:0][DATA_W-1:0] wb_data;
  logic [NREQ-1:0]             wb_ready;
  logic                        rf_we;
  logic [ADDR_W-1:0]           rf_waddr;
  logic [DATA_W-1:0]           rf_wdata;
  logic                        issue_valid;
  logic [ADDR_W-1:0]           issue_addr;
  logic                        issue_ready;
  logic [ADDR_W-1:0]           chk_rs;
  logic [ADDR_W-1:0]           chk_rt;
  logic                        rs_busy;
  logic                        rt_busy;

  modport slave (
    input  wb_valid, wb_addr, wb_data, issue_valid, issue_addr, chk_rs, chk_rt,
    output wb_ready, rf_we, rf_waddr, rf_wdata, issue_ready, rs_busy, rt_busy
  );
  modport master (
    output wb_valid, wb_addr, wb_data, issue_valid, issue_addr, chk_rs, chk_rt,
    input  wb_ready, rf_we, rf_waddr, rf_wdata, issue_ready, rs_busy, rt_busy
  );
endinterface

// File: rtl/regfile_write_scheduler_arbiter.sv
// Round-robin arbiter: grants the first request at or after the rotating pointer.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;
  logic          w_found;
  int            w_idx;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(r_ptr) + k) % N;
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
        w_gidx     = PW'(w_idx);
      end
    end
  end

  // Pointer moves past the winner; idle cycles leave it where it is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_ptr <= '0;
    else if (w_found) r_ptr <= PW'((int'(w_gidx) + 1) % N);
  end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port among NREQ writeback units and tracks
// per-register pending writes for decode RAW/WAW stalls.
module regfile_write_scheduler
  import mips_rf_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = mips_rf_pkg::DATA_W,
  parameter int ADDR_W = mips_rf_pkg::ADDR_W
) (
  input logic clk,
  input logic reset,
  regfile_write_scheduler_if.slave bus
);
  logic [NREQ-1:0]     w_req;
  logic [NREQ-1:0]     w_gnt;
  logic [ADDR_W-1:0]   w_gaddr;
  logic [DATA_W-1:0]   w_gdata;
  logic                w_any;
  logic                w_clr;
  logic                w_set;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;

  // Requests are masked during reset so no grant is visible while it is held.
  assign w_req = bus.wb_valid & {NREQ{~reset}};

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (w_req),
    .gnt   (w_gnt)
  );

  always_comb begin
    w_gaddr = '0;
    w_gdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gaddr = w_gaddr | (bus.wb_addr[i] & {ADDR_W{w_gnt[i]}});
      w_gdata = w_gdata | (bus.wb_data[i] & {DATA_W{w_gnt[i]}});
    end
  end

  assign w_any = |w_gnt;
  assign w_clr = w_any && (w_gaddr != ADDR_W'(REG_ZERO));
  assign w_set = bus.issue_valid && bus.issue_ready && (bus.issue_addr != ADDR_W'(REG_ZERO));

  // Set is applied after clear so a same-cycle issue to the committing register wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (w_clr) r_busy[w_gaddr] <= 1'b0;
      if (w_set) r_busy[bus.issue_addr] <= 1'b1;
    end
  end

  // Writes to r0 are accepted and swallowed; addr/data only move on a real write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_clr;
      if (w_clr) begin
        r_waddr <= w_gaddr;
        r_wdata <= w_gdata;
      end
    end
  end

  assign bus.wb_ready    = w_gnt;
  assign bus.rf_we       = r_we;
  assign bus.rf_waddr    = r_waddr;
  assign bus.rf_wdata    = r_wdata;
  assign bus.issue_ready = !r_busy[bus.issue_addr] || (bus.issue_addr == ADDR_W'(REG_ZERO));
  assign bus.rs_busy     = r_busy[bus.chk_rs];
  assign bus.rt_busy     = r_busy[bus.chk_rt];
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler (NREQ=2).
module tb_regfile_write_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler_if #(.NREQ(2)) bus ();

  regfile_write_scheduler #(.NREQ(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.wb_valid    = 2'b00;
    bus.issue_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.wb_valid = 2'b11; bus.wb_addr[0] = 5'd1; bus.wb_addr[1] = 5'd2;
    bus.wb_data[0] = 32'h0; bus.wb_data[1] = 32'h0;
    bus.issue_valid = 1'b0; bus.issue_addr = 5'd7;
    bus.chk_rs = 5'd7; bus.chk_rt = 5'd8;
    step(); step();
    n_chk++; if (bus.wb_ready !== 2'b00) begin n_err++; $display("FAIL reset_wb_ready got %b want 00", bus.wb_ready); end
    n_chk++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got %b want 0", bus.rf_we); end
    n_chk++; if (bus.rf_waddr !== 5'd0) begin n_err++; $display("FAIL reset_rf_waddr got %0d want 0", bus.rf_waddr); end
    n_chk++; if (bus.rf_wdata !== 32'h0) begin n_err++; $display("FAIL reset_rf_wdata got %h want 0", bus.rf_wdata); end
    n_chk++; if (bus.rs_busy !== 1'b0 || bus.rt_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got rs=%b rt=%b want 0 0", bus.rs_busy, bus.rt_busy); end
    n_chk++; if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_issue_ready got %b want 1", bus.issue_ready); end
    idle_inputs();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single;
    bus.wb_valid = 2'b01; bus.wb_addr[0] = 5'd5; bus.wb_data[0] = 32'hDEADBEEF;
    #1;
    n_chk++; if (bus.wb_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got %b want 01", bus.wb_ready); end
    step();
    idle_inputs();
    n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL single_write got we=%b a=%0d d=%h want 1 5 deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    step();
    n_chk++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd5)
      begin n_err++; $display("FAIL single_idle got we=%b a=%0d want 0 5", bus.rf_we, bus.rf_waddr); end
  endtask

  task automatic test_alternate;
    logic [1:0]  exp_rdy;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    reset = 1'b1; step(); reset = 1'b0;
    bus.wb_valid = 2'b11;
    bus.wb_addr[0] = 5'd3; bus.wb_data[0] = 32'h0000_0100;
    bus.wb_addr[1] = 5'd4; bus.wb_data[1] = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a   = (i % 2 == 0) ? 5'd3 : 5'd4;
      exp_d   = (i % 2 == 0) ? 32'h100 : 32'h200;
      #1;
      n_chk++; if (bus.wb_ready !== exp_rdy) begin n_err++; $display("FAIL alt_ready[%0d] got %b want %b", i, bus.wb_ready, exp_rdy); end
      step();
      n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== exp_a || bus.rf_wdata !== exp_d)
        begin n_err++; $display("FAIL alt_write[%0d] got we=%b a=%0d d=%h want 1 %0d %h", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_a, exp_d); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_scoreboard;
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd7;
    #1;
    n_chk++; if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL sb_issue_free got %b want 1", bus.issue_ready); end
    step();
    bus.issue_valid = 1'b0;
    bus.chk_rs = 5'd7; bus.chk_rt = 5'd8;
    #1;
    n_chk++; if (bus.rs_busy !== 1'b1) begin n_err++; $display("FAIL sb_rs_busy got %b want 1", bus.rs_busy); end
    n_chk++; if (bus.rt_busy !== 1'b0) begin n_err++; $display("FAIL sb_rt_free got %b want 0", bus.rt_busy); end
    n_chk++; if (bus.issue_ready !== 1'b0) begin n_err++; $display("FAIL sb_waw_stall got %b want 0", bus.issue_ready); end
    bus.wb_valid = 2'b10; bus.wb_addr[1] = 5'd7; bus.wb_data[1] = 32'hCAFE_0007;
    #1;
    n_chk++; if (bus.wb_ready !== 2'b10) begin n_err++; $display("FAIL sb_wb1_ready got %b want 10", bus.wb_ready); end
    n_chk++; if (bus.rs_busy !== 1'b1) begin n_err++; $display("FAIL sb_no_bypass got %b want 1", bus.rs_busy); end
    step();
    idle_inputs();
    #1;
    n_chk++; if (bus.rs_busy !== 1'b0 || bus.issue_ready !== 1'b1)
      begin n_err++; $display("FAIL sb_cleared got rs=%b ir=%b want 0 1", bus.rs_busy, bus.issue_ready); end
    n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'hCAFE_0007)
      begin n_err++; $display("FAIL sb_write got we=%b a=%0d d=%h want 1 7 cafe0007", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
  endtask

  task automatic test_set_wins;
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
    bus.wb_valid = 2'b01; bus.wb_addr[0] = 5'd9; bus.wb_data[0] = 32'h9999;
    bus.chk_rs = 5'd9;
    #1;
    n_chk++; if (bus.wb_ready !== 2'b01 || bus.issue_ready !== 1'b1)
      begin n_err++; $display("FAIL sw_pre got rdy=%b ir=%b want 01 1", bus.wb_ready, bus.issue_ready); end
    step();
    idle_inputs();
    #1;
    n_chk++; if (bus.rs_busy !== 1'b1) begin n_err++; $display("FAIL sw_set_wins got %b want 1", bus.rs_busy); end
    n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9) begin n_err++; $display("FAIL sw_write got we=%b a=%0d want 1 9", bus.rf_we, bus.rf_waddr); end
    bus.wb_valid = 2'b10; bus.wb_addr[1] = 5'd9; bus.wb_data[1] = 32'h9A9A;
    #1;
    n_chk++; if (bus.wb_ready !== 2'b10) begin n_err++; $display("FAIL sw_clear_ready got %b want 10", bus.wb_ready); end
    step();
    idle_inputs();
    #1;
    n_chk++; if (bus.rs_busy !== 1'b0) begin n_err++; $display("FAIL sw_cleared got %b want 0", bus.rs_busy); end
  endtask

  task automatic test_reg0;
    bus.wb_valid = 2'b01; bus.wb_addr[0] = 5'd0; bus.wb_data[0] = 32'h1;
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd0;
    bus.chk_rs = 5'd0; bus.chk_rt = 5'd0;
    #1;
    n_chk++; if (bus.wb_ready !== 2'b01) begin n_err++; $display("FAIL r0_ready got %b want 01", bus.wb_ready); end
    n_chk++; if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL r0_issue_ready got %b want 1", bus.issue_ready); end
    step();
    idle_inputs();
    #1;
    n_chk++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL r0_no_we got %b want 0", bus.rf_we); end
    n_chk++; if (bus.rs_busy !== 1'b0 || bus.rt_busy !== 1'b0)
      begin n_err++; $display("FAIL r0_busy got rs=%b rt=%b want 0 0", bus.rs_busy, bus.rt_busy); end
  endtask

  task automatic test_reset_mid;
    bus.wb_valid = 2'b01; bus.wb_addr[0] = 5'd12; bus.wb_data[0] = 32'hAB;
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd13;
    step();
    idle_inputs();
    bus.chk_rs = 5'd13;
    #1;
    n_chk++; if (bus.rf_we !== 1'b1 || bus.rs_busy !== 1'b1)
      begin n_err++; $display("FAIL mid_pre got we=%b rs=%b want 1 1", bus.rf_we, bus.rs_busy); end
    #1 reset = 1'b1;
    #1;
    n_chk++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0)
      begin n_err++; $display("FAIL mid_rf got we=%b a=%0d want 0 0", bus.rf_we, bus.rf_waddr); end
    n_chk++; if (bus.rs_busy !== 1'b0 || bus.issue_ready !== 1'b1)
      begin n_err++; $display("FAIL mid_busy got rs=%b ir=%b want 0 1", bus.rs_busy, bus.issue_ready); end
    bus.wb_valid = 2'b11;
    #1;
    n_chk++; if (bus.wb_ready !== 2'b00) begin n_err++; $display("FAIL mid_ready got %b want 00", bus.wb_ready); end
    idle_inputs();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_scoreboard();
    test_set_wins();
    test_reg0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
